multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multicycle RV32I core: sequences the shared ALU, register file, PC/IR registers and a single unified instruction/data memory port over multiple cycles per instruction. Decodes the opcode/funct fields produced by the instruction encoders (R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI), drives every datapath mux select and write enable, and stalls on a variable-latency memory handshake. Unsupported encodings park the FSM in a sticky trap state.

## Interface
- No parameters.
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- zero, lt, ltu  in  1 each  combinational ALU flags: result==0, signed rs1<rs2, unsigned rs1<rs2.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request; held until mem_ready.
- mem_write  out  1  request is a store (only with mem_req).
- adr_src  out  1  0 = PC, 1 = ALUOut.
- ir_write, pc_write, reg_write  out  1 each  register enables.
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1.
- alu_src_b  out  2  00 rs2, 01 immediate, 10 constant 4.
- result_src  out  2  00 ALUOut, 01 memory data, 10 ALU result (direct).
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- alu_control  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASS_B.
- illegal  out  1  sticky trap indicator.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALR_PC, LUI, TRAP.
- Unlisted outputs are 0 in every state.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, ADD, result_src=10. On mem_ready: ir_write=1, pc_write=1, go to DECODE; otherwise stay.
- DECODE: a=01, b=01, imm_src=B, ADD (branch target into ALUOut). Next state by op: LOAD/STORE→MEMADR, R→EXECR, I→EXECI, BRANCH→BRANCH, JAL→JAL, JALR→JALR, LUI→LUI, anything else→TRAP.
- MEMADR: a=10, b=01, ADD, imm_src = I for loads and S for stores. Next: MEMREAD for loads, MEMWRITE for stores. funct3≠010 goes to TRAP instead.
- MEMREAD: mem_req=1, adr_src=1; on mem_ready go to MEMWB.
- MEMWB: result_src=01, reg_write=1, go to FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1; on mem_ready go to FETCH.
- EXECR: a=10, b=00. alu_control from funct3: 000 ADD (SUB if funct7b5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7b5), 110 OR, 111 AND. Go to ALUWB.
- EXECI: a=10, b=01, imm_src=I. Same mapping as EXECR, except funct3 000 is always ADD; funct7b5 is honoured only for 101. Go to ALUWB.
- LUI: b=01, imm_src=U, PASS_B, go to ALUWB.
- ALUWB: result_src=00, reg_write=1, go to FETCH.
- BRANCH: a=10, b=00, SUB. Taken condition by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu. If taken: pc_write=1, result_src=00. Go to FETCH. funct3 010/011 go to TRAP.
- JAL: pc_write=1, result_src=00; a=01, b=10, ADD (OldPC+4). Go to ALUWB.
- JALR: a=10, b=01, imm_src=I, ADD. Go to JALR_PC. The datapath clears bit 0 of the target.
- JALR_PC: pc_write=1, result_src=00; a=01, b=10, ADD. Go to ALUWB.
- TRAP: illegal=1, all enables 0. Left only by reset.

## Timing
- Reset (async, reset_n=0): state=FETCH immediately. All outputs read 0, including mem_req and illegal, while reset_n is low. FETCH outputs appear on the first cycle after release.
- Outputs are a Moore function of state, except: FETCH's ir_write/pc_write (gated by mem_ready), BRANCH's pc_write (flags), and MEMADR/EXEC*/BRANCH decode fields.
- mem_ready is ignored when mem_req=0. Zero-wait memory is allowed (mem_ready high in the first request cycle).
- Reset during a pending memory request abandons it. mem_req drops asynchronously.
- Cycle counts with zero-wait memory: R/I/LUI 4, LOAD 5, STORE 4, BRANCH 3, JAL 4, JALR 5. Each wait cycle adds 1 per memory access.

## Test plan
- Reset, then fetch `add x3,x1,x2` (0x002081B3) with mem_ready high: states FETCH,DECODE,EXECR,ALUWB; reg_write=1 in cycle 4; alu_control=0.
- `lw x5,8(x2)` (0x00812283) with mem_ready delayed 3 cycles on the data access: mem_req/adr_src=1 held 4 cycles in MEMREAD; reg_write with result_src=01 once; total 8 cycles.
- `beq x1,x2,+16` (0x00208863): zero=1 gives pc_write=1 in cycle 3; zero=0 gives pc_write=0. Repeat bltu with ltu=1 (taken).
- `srai x4,x4,3` (0x40325213): alu_control=9, b=01. `addi` with IR[30]=1: alu_control=0.
- `jalr x1,4(x6)` (0x004300E7): JALR then JALR_PC (pc_write=1, result_src=00) then ALUWB (reg_write=1).
- Opcode 0x7F: TRAP after DECODE, illegal=1 and held; reset_n low mid-trap clears it. reset_n low during a MEMWRITE wait drops mem_req the same cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core.
// Sequences ALU, register file, PC/IR and one shared memory port.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD,
    S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR,
    S_JALR_PC, S_LUI, S_TRAP
  } state_t;

  state_t state_q, state_d;

  // alt selects SUB for funct3 000 and SRA for funct3 101
  function automatic logic [3:0] alu_dec(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] r;
    unique case (f3)
      3'b000: r = alt ? ALU_SUB : ALU_ADD;
      3'b001: r = ALU_SLL;
      3'b010: r = ALU_SLT;
      3'b011: r = ALU_SLTU;
      3'b100: r = ALU_XOR;
      3'b101: r = alt ? ALU_SRA : ALU_SRL;
      3'b110: r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  logic br_taken;
  logic br_legal;
  logic mem_legal;

  always_comb begin
    br_taken = 1'b0;
    unique case (funct3)
      3'b000: br_taken = zero;
      3'b001: br_taken = !zero;
      3'b100: br_taken = lt;
      3'b101: br_taken = !lt;
      3'b110: br_taken = ltu;
      3'b111: br_taken = !ltu;
      default: br_taken = 1'b0;
    endcase
  end

  assign br_legal  = funct3[2:1] != 2'b01;
  assign mem_legal = funct3 == 3'b010;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:
        if (mem_ready) state_d = S_DECODE;
      S_DECODE:
        case (op)
          OP_LOAD,
          OP_STORE: state_d = S_MEMADR;
          OP_R:     state_d = S_EXECR;
          OP_I:     state_d = S_EXECI;
          OP_BR:    state_d = S_BRANCH;
          OP_JAL:   state_d = S_JAL;
          OP_JALR:  state_d = S_JALR;
          OP_LUI:   state_d = S_LUI;
          default:  state_d = S_TRAP;
        endcase
      S_MEMADR:
        if (!mem_legal)        state_d = S_TRAP;
        else if (op == OP_LOAD) state_d = S_MEMREAD;
        else                   state_d = S_MEMWRITE;
      S_MEMREAD:
        if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWRITE:
        if (mem_ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI,
      S_LUI,
      S_JAL:     state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:
        state_d = br_legal ? S_FETCH : S_TRAP;
      S_JALR:    state_d = S_JALR_PC;
      S_JALR_PC: state_d = S_ALUWB;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_TRAP;
    endcase
  end

  // Outputs are forced low while reset is held so a pending
  // memory request drops without waiting for a clock edge.
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    imm_src     = IMM_I;
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = IMM_B;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src   = (op == OP_LOAD) ? IMM_I : IMM_S;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXECR: begin
          alu_src_a   = 2'b10;
          alu_control = alu_dec(funct3, funct7b5);
        end
        S_EXECI: begin
          alu_src_a   = 2'b10;
          alu_src_b   = 2'b01;
          alu_control = alu_dec(funct3,
                          funct7b5 && funct3 == 3'b101);
        end
        S_LUI: begin
          alu_src_b   = 2'b01;
          imm_src     = IMM_U;
          alu_control = ALU_PASS;
        end
        S_ALUWB:
          reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a   = 2'b10;
          alu_control = ALU_SUB;
          pc_write    = br_legal && br_taken;
        end
        S_JAL,
        S_JALR_PC: begin
          pc_write  = 1'b1;
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
        end
        S_JALR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_TRAP:
          illegal = 1'b1;
        default:
          illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: driver queues the expected
// control vector per cycle, a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src;
  logic       ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic       illegal;

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src),
    .alu_control(alu_control), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [19:0] v;
  } exp_t;

  exp_t sb[$];
  int   applied = 0;
  int   miscmp  = 0;

  logic [19:0] got;
  assign got = {mem_req, mem_write, adr_src, ir_write,
                pc_write, reg_write, alu_src_a, alu_src_b,
                result_src, imm_src, alu_control, illegal};

  function automatic logic [19:0] ev(
    input logic mr, mw, as, iw, pw, rw,
    input logic [1:0] a, b, rs,
    input logic [2:0] imm,
    input logic [3:0] alu,
    input logic ill
  );
    return {mr, mw, as, iw, pw, rw, a, b, rs, imm, alu, ill};
  endfunction

  function automatic logic [19:0] v_fetch(input logic r);
    return ev(1,0,0,r,r,0,2'd0,2'd2,2'd2,3'd0,4'd0,0);
  endfunction
  function automatic logic [19:0] v_memadr(input logic [2:0] i);
    return ev(0,0,0,0,0,0,2'd2,2'd1,2'd0,i,4'd0,0);
  endfunction
  function automatic logic [19:0] v_execr(input logic [3:0] a);
    return ev(0,0,0,0,0,0,2'd2,2'd0,2'd0,3'd0,a,0);
  endfunction
  function automatic logic [19:0] v_execi(input logic [3:0] a);
    return ev(0,0,0,0,0,0,2'd2,2'd1,2'd0,3'd0,a,0);
  endfunction
  function automatic logic [19:0] v_branch(input logic pw);
    return ev(0,0,0,0,pw,0,2'd2,2'd0,2'd0,3'd0,4'd1,0);
  endfunction

  localparam logic [19:0] V_ZERO  = 20'd0;
  localparam logic [19:0] V_DEC   =
    {6'b000000, 2'd1, 2'd1, 2'd0, 3'd2, 4'd0, 1'b0};
  localparam logic [19:0] V_MEMRD =
    {6'b101000, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 1'b0};
  localparam logic [19:0] V_MEMWB =
    {6'b000001, 2'd0, 2'd0, 2'd1, 3'd0, 4'd0, 1'b0};
  localparam logic [19:0] V_MEMWR =
    {6'b111000, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 1'b0};
  localparam logic [19:0] V_ALUWB =
    {6'b000001, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 1'b0};
  localparam logic [19:0] V_LUI   =
    {6'b000000, 2'd0, 2'd1, 2'd0, 3'd4, 4'd10, 1'b0};
  localparam logic [19:0] V_JMPPC =
    {6'b000010, 2'd1, 2'd2, 2'd0, 3'd0, 4'd0, 1'b0};
  localparam logic [19:0] V_JALR  =
    {6'b000000, 2'd2, 2'd1, 2'd0, 3'd0, 4'd0, 1'b0};
  localparam logic [19:0] V_TRAP  =
    {6'b000000, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 1'b1};

  // One cycle: drive inputs just after the edge, queue expectation.
  task automatic step(
    input string       tag,
    input logic [31:0] ins,
    input logic        rst,
    input logic        rdy,
    input logic [2:0]  fl,
    input logic [19:0] e
  );
    exp_t x;
    @(posedge clk);
    #1;
    reset_n   = rst;
    op        = ins[6:0];
    funct3    = ins[14:12];
    funct7b5  = ins[30];
    mem_ready = rdy;
    {zero, lt, ltu} = fl;
    x.tag = tag;
    x.v   = e;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      applied++;
      if (got !== x.v) begin
        miscmp++;
        $display("FAIL %s got=%05h exp=%05h", x.tag, got, x.v);
      end
    end
  end

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_LW   = 32'h00812283;
  localparam logic [31:0] I_LB   = 32'h00810283;
  localparam logic [31:0] I_SW   = 32'h00112423;
  localparam logic [31:0] I_BEQ  = 32'h00208863;
  localparam logic [31:0] I_BNE  = 32'h00209863;
  localparam logic [31:0] I_BLTU = 32'h0020E863;
  localparam logic [31:0] I_B010 = 32'h0020A863;
  localparam logic [31:0] I_SRAI = 32'h40325213;
  localparam logic [31:0] I_ADDI = 32'h40008093;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_JALR = 32'h004300E7;
  localparam logic [31:0] I_LUI  = 32'h000012B7;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  initial begin
    int wait_cyc;
    step("rst0", I_ADD, 0, 1, 3'b000, V_ZERO);
    step("rst1", I_ADD, 0, 1, 3'b000, V_ZERO);

    step("add_f",  I_ADD, 1, 1, 3'b000, v_fetch(1));
    step("add_d",  I_ADD, 1, 0, 3'b000, V_DEC);
    step("add_x",  I_ADD, 1, 0, 3'b000, v_execr(4'd0));
    step("add_wb", I_ADD, 1, 0, 3'b000, V_ALUWB);

    step("sub_fw", I_SUB, 1, 0, 3'b000, v_fetch(0));
    step("sub_f",  I_SUB, 1, 1, 3'b000, v_fetch(1));
    step("sub_d",  I_SUB, 1, 0, 3'b000, V_DEC);
    step("sub_x",  I_SUB, 1, 0, 3'b000, v_execr(4'd1));
    step("sub_wb", I_SUB, 1, 0, 3'b000, V_ALUWB);

    step("lw_f",   I_LW, 1, 1, 3'b000, v_fetch(1));
    step("lw_d",   I_LW, 1, 0, 3'b000, V_DEC);
    step("lw_a",   I_LW, 1, 0, 3'b000, v_memadr(3'd0));
    for (int i = 0; i < 3; i++)
      step("lw_rdw", I_LW, 1, 0, 3'b000, V_MEMRD);
    step("lw_rd",  I_LW, 1, 1, 3'b000, V_MEMRD);
    step("lw_wb",  I_LW, 1, 0, 3'b000, V_MEMWB);

    step("sw_f",   I_SW, 1, 1, 3'b000, v_fetch(1));
    step("sw_d",   I_SW, 1, 0, 3'b000, V_DEC);
    step("sw_a",   I_SW, 1, 0, 3'b000, v_memadr(3'd1));
    step("sw_w",   I_SW, 1, 1, 3'b000, V_MEMWR);

    step("beq_f",  I_BEQ, 1, 1, 3'b000, v_fetch(1));
    step("beq_d",  I_BEQ, 1, 0, 3'b000, V_DEC);
    step("beq_t",  I_BEQ, 1, 0, 3'b100, v_branch(1));
    step("beq2_f", I_BEQ, 1, 1, 3'b000, v_fetch(1));
    step("beq2_d", I_BEQ, 1, 0, 3'b000, V_DEC);
    step("beq_nt", I_BEQ, 1, 0, 3'b011, v_branch(0));
    step("bne_f",  I_BNE, 1, 1, 3'b000, v_fetch(1));
    step("bne_d",  I_BNE, 1, 0, 3'b000, V_DEC);
    step("bne_nt", I_BNE, 1, 0, 3'b100, v_branch(0));
    step("bltu_f", I_BLTU, 1, 1, 3'b000, v_fetch(1));
    step("bltu_d", I_BLTU, 1, 0, 3'b000, V_DEC);
    step("bltu_t", I_BLTU, 1, 0, 3'b001, v_branch(1));

    step("srai_f", I_SRAI, 1, 1, 3'b000, v_fetch(1));
    step("srai_d", I_SRAI, 1, 0, 3'b000, V_DEC);
    step("srai_x", I_SRAI, 1, 0, 3'b000, v_execi(4'd9));
    step("srai_w", I_SRAI, 1, 0, 3'b000, V_ALUWB);
    step("addi_f", I_ADDI, 1, 1, 3'b000, v_fetch(1));
    step("addi_d", I_ADDI, 1, 0, 3'b000, V_DEC);
    step("addi_x", I_ADDI, 1, 0, 3'b000, v_execi(4'd0));
    step("addi_w", I_ADDI, 1, 0, 3'b000, V_ALUWB);

    step("lui_f",  I_LUI, 1, 1, 3'b000, v_fetch(1));
    step("lui_d",  I_LUI, 1, 0, 3'b000, V_DEC);
    step("lui_x",  I_LUI, 1, 0, 3'b000, V_LUI);
    step("lui_w",  I_LUI, 1, 0, 3'b000, V_ALUWB);

    step("jal_f",  I_JAL, 1, 1, 3'b000, v_fetch(1));
    step("jal_d",  I_JAL, 1, 0, 3'b000, V_DEC);
    step("jal_x",  I_JAL, 1, 0, 3'b000, V_JMPPC);
    step("jal_w",  I_JAL, 1, 0, 3'b000, V_ALUWB);

    step("jalr_f", I_JALR, 1, 1, 3'b000, v_fetch(1));
    step("jalr_d", I_JALR, 1, 0, 3'b000, V_DEC);
    step("jalr_x", I_JALR, 1, 0, 3'b000, V_JALR);
    step("jalr_p", I_JALR, 1, 0, 3'b000, V_JMPPC);
    step("jalr_w", I_JALR, 1, 0, 3'b000, V_ALUWB);

    step("bad_f",  I_BAD, 1, 1, 3'b000, v_fetch(1));
    step("bad_d",  I_BAD, 1, 1, 3'b000, V_DEC);
    for (int i = 0; i < 3; i++)
      step("trap", I_BAD, 1, 1, 3'b111, V_TRAP);
    step("trap_rst", I_ADD, 0, 1, 3'b000, V_ZERO);
    step("trap_rel", I_ADD, 1, 0, 3'b000, v_fetch(0));

    step("lb_f",   I_LB, 1, 1, 3'b000, v_fetch(1));
    step("lb_d",   I_LB, 1, 0, 3'b000, V_DEC);
    step("lb_a",   I_LB, 1, 0, 3'b000, v_memadr(3'd0));
    step("lb_trap", I_LB, 1, 1, 3'b000, V_TRAP);
    step("lb_rst", I_LB, 0, 1, 3'b000, V_ZERO);

    step("b010_f", I_B010, 1, 1, 3'b000, v_fetch(1));
    step("b010_d", I_B010, 1, 0, 3'b000, V_DEC);
    step("b010_b", I_B010, 1, 0, 3'b100, v_branch(0));
    step("b010_t", I_B010, 1, 0, 3'b000, V_TRAP);
    step("b010_r", I_B010, 0, 0, 3'b000, V_ZERO);

    step("sww_f",  I_SW, 1, 1, 3'b000, v_fetch(1));
    step("sww_d",  I_SW, 1, 0, 3'b000, V_DEC);
    step("sww_a",  I_SW, 1, 0, 3'b000, v_memadr(3'd1));
    step("sww_w",  I_SW, 1, 0, 3'b000, V_MEMWR);
    step("sww_rst", I_SW, 0, 0, 3'b000, V_ZERO);
    step("sww_rel", I_SW, 1, 1, 3'b000, v_fetch(1));

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      miscmp++;
      $display("FAIL drain got=%0d left exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscmp);
    $finish;
  end

endmodule
